// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB initiator bridging single CPU requests to decoded APB slaves
module apb_master_bridge #(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          TIMEOUT    = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     transfer,
    input  logic                     write,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     ready,
    output logic                     err,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [32*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY
);

    // Counter only needs to reach TIMEOUT-1; a 1-bit counter covers the disabled/degenerate cases.
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             paddr_q, paddr_d;
    logic [31:0]             pwdata_q, pwdata_d;
    logic                    pwrite_q, pwrite_d;
    logic                    penable_q, penable_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [3:0]              idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    addr_hit;
    logic [31:0]             prdata_sel;
    logic                    pready_sel;

    // Decode the incoming request: upper half must match the window, slot must exist.
    always_comb begin
        addr_hit = (addr[31:16] == BASE_ADDR[31:16]) && (int'(addr[15:12]) < NUM_SLAVES);
    end

    // Pick out only the selected slave's response; all other slaves are ignored.
    always_comb begin
        prdata_sel = 32'd0;
        pready_sel = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == 4'(i)) begin
                prdata_sel = PRDATA[32*i +: 32];
                pready_sel = PREADY[i];
            end
        end
    end

    // Next-state and registered APB/CPU outputs, updated on entry to each state.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;
        psel_d    = psel_q;
        rdata_d   = rdata_q;
        ready_d   = ready_q;
        err_d     = err_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                psel_d    = '0;
                penable_d = 1'b0;
                ready_d   = 1'b0;
                err_d     = 1'b0;
                rdata_d   = 32'd0;
                if (transfer) begin
                    if (addr_hit) begin
                        paddr_d  = addr;
                        pwdata_d = wdata;
                        pwrite_d = write;
                        idx_d    = addr[15:12];
                        cnt_d    = '0;
                        psel_d   = NUM_SLAVES'(1) << addr[15:12];
                        state_d  = ST_SETUP;
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_sel) begin
                    rdata_d   = pwrite_q ? 32'd0 : prdata_sel;
                    err_d     = 1'b0;
                    ready_d   = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d   = 32'd0;
                    err_d     = 1'b1;
                    ready_d   = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                ready_d = 1'b0;
                err_d   = 1'b0;
                rdata_d = 32'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q   <= ST_IDLE;
            paddr_q   <= 32'd0;
            pwdata_q  <= 32'd0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            rdata_q   <= 32'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= 4'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            psel_q    <= psel_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PENABLE = penable_q;
    assign PSEL    = psel_q;
    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;

endmodule
